// File: rtl/nbcd_updown_counter_if.sv
// nbcd_updown_counter_if
//   Control/data bundle for one N-digit BCD up/down counter stage.
//   master : drives m_ei, m_up, m_load, m_d; observes q, eu, load_err
//   slave  : the counter itself
//   Signals
//     m_ei      count enable / carry-borrow in from a lower stage
//     m_up      direction, 1 = up, 0 = down
//     m_load    synchronous parallel load strobe
//     m_d       packed BCD load value, digit 0 in [3:0]
//     q         registered packed BCD count
//     eu        combinational carry/borrow out (feed to next stage m_ei)
//     load_err  one-cycle flag, previous load held a non-BCD digit
interface nbcd_updown_counter_if #(
  parameter int N_DIGITS = 4
);
  logic                  m_ei;
  logic                  m_up;
  logic                  m_load;
  logic [4*N_DIGITS-1:0] m_d;
  logic [4*N_DIGITS-1:0] q;
  logic                  eu;
  logic                  load_err;

  modport master (
    output m_ei, m_up, m_load, m_d,
    input  q, eu, load_err
  );

  modport slave (
    input  m_ei, m_up, m_load, m_d,
    output q, eu, load_err
  );
endinterface

// File: rtl/nbcd_updown_counter.sv
// nbcd_updown_counter
//   Parameterised N-digit BCD counter: count enable, up/down, synchronous
//   parallel load with BCD validation, wrap or saturate at the terminal value.
//   Stages cascade by feeding eu into the next stage's m_ei.
//   Parameters
//     N_DIGITS  number of BCD digits (1..8), digit k at q[4k+3:4k]
//     WRAP      1 = wrap at terminal, 0 = saturate at terminal
//   Ports
//     m_clock   rising-edge clock
//     m_reset   synchronous active-high reset (clears q and load_err)
//     bus       slave side of nbcd_updown_counter_if (m_ei, m_up, m_load,
//               m_d in; q, eu, load_err out)

// Single decimal digit step: +1 / -1 with 9<->0 roll. Purely combinational;
// the parent decides which digits step on a given edge.
module nbcd_digit (
  input  logic [3:0] cur,
  input  logic       step,
  input  logic       up,
  output logic [3:0] nxt
);
  always_comb begin
    nxt = cur;
    if (step) begin
      if (up) nxt = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
      else    nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    end
  end
endmodule

module nbcd_updown_counter #(
  parameter int N_DIGITS = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic                  m_clock,
  input  logic                  m_reset,
  nbcd_updown_counter_if.slave  bus
);

  logic [N_DIGITS-1:0][3:0] q_r;      // current count, one nibble per digit
  logic [N_DIGITS-1:0][3:0] d_fix;    // load value with non-BCD digits zeroed
  logic [N_DIGITS-1:0][3:0] cnt_nxt;  // count value after one step
  logic [N_DIGITS-1:0]      bad;      // load digit k is > 9
  logic [N_DIGITS-1:0]      step;     // digit k steps this edge
  logic [N_DIGITS:0]        all9;     // all9[k]: digits below k are all 9
  logic [N_DIGITS:0]        all0;     // all0[k]: digits below k are all 0
  logic                     at_term;
  logic                     sat_hold;
  logic                     load_err_r;

  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  // Ripple prefix terms: a digit moves only when every lower digit is at
  // its roll point for the current direction.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    logic [3:0] d_dig;
    assign d_dig      = bus.m_d[4*k +: 4];
    assign bad[k]     = (d_dig > 4'd9);
    assign d_fix[k]   = bad[k] ? 4'd0 : d_dig;
    assign all9[k+1]  = all9[k] & (q_r[k] == 4'd9);
    assign all0[k+1]  = all0[k] & (q_r[k] == 4'd0);
    assign step[k]    = bus.m_up ? all9[k] : all0[k];
  end

  nbcd_digit u_dig [N_DIGITS-1:0] (
    .cur  (q_r),
    .step (step),
    .up   (bus.m_up),
    .nxt  (cnt_nxt)
  );

  // Terminal is direction-dependent: 9..9 going up, 0..0 going down.
  // With wrap, the digit steps already produce 0..0 / 9..9 at terminal,
  // so only saturate mode needs an explicit hold.
  assign at_term  = bus.m_up ? all9[N_DIGITS] : all0[N_DIGITS];
  assign sat_hold = at_term & ~WRAP;

  always_ff @(posedge m_clock) begin
    if (m_reset) begin
      q_r        <= '0;
      load_err_r <= 1'b0;
    end else if (bus.m_load) begin
      q_r        <= d_fix;
      load_err_r <= |bad;
    end else begin
      load_err_r <= 1'b0;
      if (bus.m_ei && !sat_hold) q_r <= cnt_nxt;
    end
  end

  // eu stays asserted at terminal even when saturating, so upper stages
  // in a cascade still advance. A load masks it for that cycle.
  assign bus.eu       = bus.m_ei & ~bus.m_load & at_term;
  assign bus.q        = q_r;
  assign bus.load_err = load_err_r;

endmodule
